// File: rtl/fpu_align_pkg.sv
// rtl/fpu_align_pkg.sv - shared widths, operand/stage types and rounding-mode codes for the FPU align front end
package fpu_align_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_OP_W   = 1 + FP_EXP_W + FP_FRAC_W;
  localparam int FP_SIG_W  = FP_FRAC_W + 4;

  localparam logic [2:0] FRM_RNE = 3'b000;
  localparam logic [2:0] FRM_RTZ = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_op_t;

  // Stage-1 bundle for the default binary32 format; sig_* are {hidden, frac, g, r, s}.
  typedef struct packed {
    logic [FP_EXP_W-1:0] diff;
    logic [FP_SIG_W-1:0] sig_sh;
    logic [FP_SIG_W-1:0] sig_ns;
    logic                sign_sh;
    logic                sign_ns;
    logic [FP_EXP_W-1:0] exp_max;
    logic [2:0]          frm;
    logic                swapped;
    logic                nan;
    logic                inf;
  } align_s1_t;

endpackage

// File: rtl/fp_sticky_rshift.sv
// rtl/fp_sticky_rshift.sv - combinational right shifter folding shifted-out bits into a sticky LSB
module fp_sticky_rshift #(
  parameter int W    = 27,
  parameter int SH_W = 8
) (
  input  logic [W-1:0]    sig_i,
  input  logic [SH_W-1:0] shamt_i,
  output logic [W-1:0]    sig_o
);

  logic [W-1:0] shifted;
  logic [W-1:0] lost_mask;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sig_o     = '0;
    // Shifts of W or more leave only the sticky bit.
    if (32'(shamt_i) >= W) begin
      sig_o = {{(W-1){1'b0}}, |sig_i};
    end else begin
      shifted   = sig_i >> shamt_i;
      lost_mask = ~({W{1'b1}} << shamt_i);
      sig_o     = {shifted[W-1:1], shifted[0] | (|(sig_i & lost_mask))};
    end
  end

endmodule

// File: rtl/fp_add_align_pipe.sv
// rtl/fp_add_align_pipe.sv - two-stage stallable exponent compare and significand alignment for the FPU adder
module fp_add_align_pipe
  import fpu_align_pkg::*;
#(
  parameter  int EXP_W  = FP_EXP_W,
  parameter  int FRAC_W = FP_FRAC_W,
  localparam int OP_W   = 1 + EXP_W + FRAC_W,
  localparam int SIG_W  = FRAC_W + 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  floating_point1_in,
  input  logic [OP_W-1:0]  floating_point2_in,
  input  logic [2:0]       frm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       frm_out,
  output logic             sign_shifted,
  output logic [SIG_W-1:0] frac_shifted,
  output logic             sign_not_shifted,
  output logic [SIG_W-1:0] frac_not_shifted,
  output logic [EXP_W-1:0] exp_max,
  output logic             swapped,
  output logic             nan_flag,
  output logic             inf_flag
);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } op_t;

  typedef struct packed {
    logic [EXP_W-1:0] diff;
    logic [SIG_W-1:0] sig_sh;
    logic [SIG_W-1:0] sig_ns;
    logic             sign_sh;
    logic             sign_ns;
    logic [EXP_W-1:0] exp_max;
    logic [2:0]       frm;
    logic             swapped;
    logic             nan;
    logic             inf;
  } s1_t;

  typedef struct packed {
    logic [2:0]       frm;
    logic             sign_sh;
    logic [SIG_W-1:0] frac_sh;
    logic             sign_ns;
    logic [SIG_W-1:0] frac_ns;
    logic [EXP_W-1:0] exp_max;
    logic             swapped;
    logic             nan;
    logic             inf;
  } s2_t;

  op_t              op1, op2;
  logic [EXP_W-1:0] eff1, eff2;
  logic [SIG_W-1:0] sig1, sig2;
  logic             ge;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             s1_valid_q, s2_valid_q;
  logic             s2_adv;
  logic [SIG_W-1:0] sig_aligned;

  assign op1 = op_t'(floating_point1_in);
  assign op2 = op_t'(floating_point2_in);

  // Zero/subnormal operands sit at effective exponent 1 with no hidden bit.
  always_comb begin
    eff1 = (op1.exp == '0) ? EXP_W'(1) : op1.exp;
    eff2 = (op2.exp == '0) ? EXP_W'(1) : op2.exp;
    sig1 = {op1.exp != '0, op1.frac, 3'b000};
    sig2 = {op2.exp != '0, op2.frac, 3'b000};
    ge   = eff1 >= eff2;
  end

  always_comb begin
    s1_d         = '0;
    s1_d.diff    = ge ? (eff1 - eff2) : (eff2 - eff1);
    s1_d.sig_sh  = ge ? sig2 : sig1;
    s1_d.sig_ns  = ge ? sig1 : sig2;
    s1_d.sign_sh = ge ? op2.sign : op1.sign;
    s1_d.sign_ns = ge ? op1.sign : op2.sign;
    s1_d.exp_max = ge ? eff1 : eff2;
    s1_d.frm     = frm_in;
    s1_d.swapped = !ge;
    s1_d.nan     = ((op1.exp == '1) && (op1.frac != '0)) || ((op2.exp == '1) && (op2.frac != '0));
    s1_d.inf     = ((op1.exp == '1) && (op1.frac == '0)) || ((op2.exp == '1) && (op2.frac == '0));
  end

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  fp_sticky_rshift #(
    .W    (SIG_W),
    .SH_W (EXP_W)
  ) u_rshift (
    .sig_i   (s1_q.sig_sh),
    .shamt_i (s1_q.diff),
    .sig_o   (sig_aligned)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.frm     = s1_q.frm;
    s2_d.sign_sh = s1_q.sign_sh;
    s2_d.frac_sh = sig_aligned;
    s2_d.sign_ns = s1_q.sign_ns;
    s2_d.frac_ns = s1_q.sig_ns;
    s2_d.exp_max = s1_q.exp_max;
    s2_d.swapped = s1_q.swapped;
    s2_d.nan     = s1_q.nan;
    s2_d.inf     = s1_q.inf;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= s2_d;
    end
  end

  assign out_valid        = s2_valid_q;
  assign frm_out          = s2_q.frm;
  assign sign_shifted     = s2_q.sign_sh;
  assign frac_shifted     = s2_q.frac_sh;
  assign sign_not_shifted = s2_q.sign_ns;
  assign frac_not_shifted = s2_q.frac_ns;
  assign exp_max          = s2_q.exp_max;
  assign swapped          = s2_q.swapped;
  assign nan_flag         = s2_q.nan;
  assign inf_flag         = s2_q.inf;

endmodule

// File: tb/tb_fp_add_align_pipe.sv
// tb/tb_fp_add_align_pipe.sv - scoreboard bench for the align pipe with directed binary32 vectors
module tb_fp_add_align_pipe;

  typedef logic [69:0] vec_t;

  logic        CLK = 1'b0;
  logic        nRST, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] fp1, fp2;
  logic [2:0]  frm_in, frm_out;
  logic        sign_shifted, sign_not_shifted, swapped, nan_flag, inf_flag;
  logic [26:0] frac_shifted, frac_not_shifted;
  logic [7:0]  exp_max;

  logic [31:0] v_op1 [8];
  logic [31:0] v_op2 [8];
  logic [2:0]  v_frm [8];
  vec_t        v_exp [8];
  vec_t        exp_q [$];
  vec_t        act;
  vec_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          sidx;
  bit          seen;

  always #5 CLK = ~CLK;

  fp_add_align_pipe dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .floating_point1_in (fp1),
    .floating_point2_in (fp2),
    .frm_in             (frm_in),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .frm_out            (frm_out),
    .sign_shifted       (sign_shifted),
    .frac_shifted       (frac_shifted),
    .sign_not_shifted   (sign_not_shifted),
    .frac_not_shifted   (frac_not_shifted),
    .exp_max            (exp_max),
    .swapped            (swapped),
    .nan_flag           (nan_flag),
    .inf_flag           (inf_flag)
  );

  assign act = {frm_out, sign_shifted, frac_shifted, sign_not_shifted, frac_not_shifted,
                exp_max, swapped, nan_flag, inf_flag};

  function automatic vec_t mk(input logic [2:0] f, input logic ssh, input logic [26:0] fsh,
                              input logic sns, input logic [26:0] fns, input logic [7:0] em,
                              input logic sw, input logic nan, input logic inf);
    return {f, ssh, fsh, sns, fns, em, sw, nan, inf};
  endfunction

  task automatic chk(input bit ok, input string name, input vec_t a, input vec_t r);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, a, r);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (nRST && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", act, '0);
        end else begin
          mon_e = exp_q.pop_front();
          chk(act === mon_e, "result", act, mon_e);
        end
      end
    end
  end

  task automatic offer(input int idx);
    int n = 0;
    in_valid = 1'b1;
    fp1      = v_op1[idx];
    fp2      = v_op2[idx];
    frm_in   = v_frm[idx];
    @(negedge CLK);
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk(1'b0, "accept_timeout", vec_t'(in_ready), vec_t'(1));
    else exp_q.push_back(v_exp[idx]);
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string nm);
    @(negedge CLK);
    chk(out_valid === 1'b0, {nm, "_lat1"}, vec_t'(out_valid), vec_t'(0));
    @(negedge CLK);
    chk(out_valid === 1'b1, {nm, "_lat2"}, vec_t'(out_valid), vec_t'(1));
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    #1;
    chk(exp_q.size() == 0, {nm, "_drain"}, vec_t'(exp_q.size()), '0);
  endtask

  task automatic step();
    in_valid = (sidx < 4);
    if (sidx < 4) begin
      fp1    = v_op1[sidx];
      fp2    = v_op2[sidx];
      frm_in = v_frm[sidx];
    end
    @(negedge CLK);
    if (in_valid && in_ready) begin
      exp_q.push_back(v_exp[sidx]);
      sidx++;
    end
    @(posedge CLK); #1;
  endtask

  task automatic quiet_check(input string nm, input int cycles);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    chk(!seen, nm, vec_t'(seen), '0);
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v_op1[0] = 32'h3F800000; v_op2[0] = 32'h3F800000; v_frm[0] = 3'd0;
    v_exp[0] = mk(3'd0, 1'b0, 27'h4000000, 1'b0, 27'h4000000, 8'd127, 1'b0, 1'b0, 1'b0);
    v_op1[1] = 32'h3F000000; v_op2[1] = 32'h3F800000; v_frm[1] = 3'd1;
    v_exp[1] = mk(3'd1, 1'b0, 27'h2000000, 1'b0, 27'h4000000, 8'd127, 1'b1, 1'b0, 1'b0);
    v_op1[2] = 32'h3F800000; v_op2[2] = 32'h30800000; v_frm[2] = 3'd2;
    v_exp[2] = mk(3'd2, 1'b0, 27'h0000001, 1'b0, 27'h4000000, 8'd127, 1'b0, 1'b0, 1'b0);
    v_op1[3] = 32'h3F800000; v_op2[3] = 32'h3C800001; v_frm[3] = 3'd3;
    v_exp[3] = mk(3'd3, 1'b0, 27'h0100001, 1'b0, 27'h4000000, 8'd127, 1'b0, 1'b0, 1'b0);
    v_op1[4] = 32'h00000002; v_op2[4] = 32'h80000001; v_frm[4] = 3'd4;
    v_exp[4] = mk(3'd4, 1'b1, 27'h0000008, 1'b0, 27'h0000010, 8'd1, 1'b0, 1'b0, 1'b0);
    v_op1[5] = 32'h7FC00000; v_op2[5] = 32'h3F800000; v_frm[5] = 3'd0;
    v_exp[5] = mk(3'd0, 1'b0, 27'h0000001, 1'b0, 27'h6000000, 8'd255, 1'b0, 1'b1, 1'b0);
    v_op1[6] = 32'h7F800000; v_op2[6] = 32'hBF800000; v_frm[6] = 3'd1;
    v_exp[6] = mk(3'd1, 1'b1, 27'h0000001, 1'b0, 27'h4000000, 8'd255, 1'b0, 1'b0, 1'b1);
    v_op1[7] = 32'hC0000000; v_op2[7] = 32'h3F800000; v_frm[7] = 3'd2;
    v_exp[7] = mk(3'd2, 1'b0, 27'h2000000, 1'b1, 27'h4000000, 8'd128, 1'b0, 1'b0, 1'b0);

    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fp1 = '0; fp2 = '0; frm_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk(out_valid === 1'b0, "reset_out_valid", vec_t'(out_valid), '0);
    chk(act === '0, "reset_outputs", act, '0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(negedge CLK);
    chk(in_ready === 1'b1, "reset_in_ready", vec_t'(in_ready), vec_t'(1));
    @(posedge CLK); #1;

    offer(0);
    lat_check("first");
    drain("first");

    for (int i = 1; i < 8; i++) offer(i);
    drain("directed");

    // Backpressure: four pairs offered against a stalled sink.
    sidx = 0;
    out_ready = 1'b0;
    repeat (6) step();
    @(negedge CLK);
    chk(sidx == 2, "bp_accepts", vec_t'(sidx), vec_t'(2));
    chk(in_ready === 1'b0, "bp_in_ready", vec_t'(in_ready), '0);
    chk(out_valid === 1'b1, "bp_out_valid", vec_t'(out_valid), vec_t'(1));
    for (int i = 0; i < 3; i++) begin
      chk(act === v_exp[0], "bp_hold", act, v_exp[0]);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) if (sidx < 4) step();
    in_valid = 1'b0;
    chk(sidx == 4, "bp_all_accepted", vec_t'(sidx), vec_t'(4));
    drain("bp");

    // Flush while the pair is still in stage 1.
    offer(2);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    exp_q.delete();
    quiet_check("flush_s1_quiet", 4);

    // Flush with both stages full behind a stalled sink.
    out_ready = 1'b0;
    offer(3);
    offer(4);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    quiet_check("flush_full_quiet", 4);
    offer(5);
    lat_check("post_flush");
    drain("post_flush");

    // Reset with both stages full.
    out_ready = 1'b0;
    offer(0);
    offer(1);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk(act === '0, "midreset_outputs", act, '0);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    quiet_check("midreset_quiet", 4);
    offer(7);
    lat_check("post_reset");
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
